// File: rtl/hough_ll_pkg.sv
// ---------------------------------------------------------------------------
// hough_ll_pkg
// Shared definitions for the Hough linked-list scheduler:
//   - op encodings carried on req_op_i (search / append)
//   - scheduler FSM state type (2-bit)
//   - default rho / node word widths
// ---------------------------------------------------------------------------
package hough_ll_pkg;

    localparam logic OP_SEARCH = 1'b0;
    localparam logic OP_APPEND = 1'b1;

    localparam int DEF_RHO_W  = 10;
    localparam int DEF_NODE_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/hough_rr_pick.sv
// ---------------------------------------------------------------------------
// hough_rr_pick
// Combinational round-robin picker: selects the first asserted valid bit at
// or after ptr, wrapping NREQ-1 -> 0.
// Ports:
//   valid  in  NREQ   request vector
//   ptr    in  IDX_W  highest-priority index (must be < NREQ)
//   grant  out NREQ   one-hot grant (all zero when nothing valid)
//   idx    out IDX_W  index of the granted requester
//   any    out 1      at least one valid bit set
// ---------------------------------------------------------------------------
module hough_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam logic [IDX_W:0]  NREQ_V = (IDX_W+1)'(NREQ);
    localparam logic [NREQ-1:0] ONE    = NREQ'(1);

    // cand[i] is the requester index checked at priority position i
    logic [IDX_W-1:0] cand [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            localparam logic [IDX_W:0] OFF = (IDX_W+1)'(gi);
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, ptr} + OFF;
            assign cand[gi]  = (sum >= NREQ_V) ? IDX_W'(sum - NREQ_V) : IDX_W'(sum);
        end
    endgenerate

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Walk from lowest priority to highest so the closest-to-ptr hit wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (valid[cand[i]]) begin
                idx = cand[i];
                any = 1'b1;
            end
        end
        grant = any ? (ONE << idx) : '0;
    end

endmodule

// File: rtl/hough_ll_sched.sv
// ---------------------------------------------------------------------------
// hough_ll_sched
// Shares one Hough linked-list engine among NREQ vote requesters. One op at a
// time: round-robin grant, 1-cycle append/search command, wait for ll_done_i
// (or timeout), then a 1-cycle response routed back to the granted requester.
// Ports:
//   clk, rst                      clock / asynchronous active-high reset
//   req_valid_i/op_i/rho_i        per-requester op request (held until ready)
//   req_ready_o                   one-hot accept pulse (ISSUE cycle)
//   rsp_valid_o                   one-hot response pulse (RESP cycle)
//   rsp_found_o/appended_o/node_o list results, valid with rsp_valid_o
//   rsp_timeout_o                 op aborted, other rsp fields are 0
//   ll_append_o/ll_search_o       1-cycle command to list
//   ll_rho_o                      rho to list, stable until done
//   ll_done_i/append_i/found_i/node_i  list completion and results
//   busy_o                        FSM not idle
//   err_o                         sticky timeout flag
// All outputs are registered.
// ---------------------------------------------------------------------------
module hough_ll_sched
    import hough_ll_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int RHO_W   = DEF_RHO_W,
    parameter int NODE_W  = DEF_NODE_W,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ-1:0]       req_op_i,
    input  logic [NREQ*RHO_W-1:0] req_rho_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic                  rsp_found_o,
    output logic                  rsp_appended_o,
    output logic [NODE_W-1:0]     rsp_node_o,
    output logic                  rsp_timeout_o,
    output logic                  ll_append_o,
    output logic                  ll_search_o,
    output logic [RHO_W-1:0]      ll_rho_o,
    input  logic                  ll_done_i,
    input  logic                  ll_append_i,
    input  logic                  ll_found_i,
    input  logic [NODE_W-1:0]     ll_node_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  g_reg, g_next;
    logic              op_reg, op_next;
    logic [RHO_W-1:0]  rho_reg, rho_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [NREQ-1:0]   ready_reg, ready_next;
    logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;
    logic              found_reg, found_next;
    logic              appended_reg, appended_next;
    logic [NODE_W-1:0] node_reg, node_next;
    logic              timeout_reg, timeout_next;
    logic              append_cmd_reg, append_cmd_next;
    logic              search_cmd_reg, search_cmd_next;
    logic              busy_reg, busy_next;
    logic              err_reg, err_next;

    logic [NREQ-1:0]   pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    hough_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid (req_valid_i),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            g_reg          <= '0;
            op_reg         <= 1'b0;
            rho_reg        <= '0;
            cnt_reg        <= '0;
            ptr_reg        <= '0;
            ready_reg      <= '0;
            rsp_valid_reg  <= '0;
            found_reg      <= 1'b0;
            appended_reg   <= 1'b0;
            node_reg       <= '0;
            timeout_reg    <= 1'b0;
            append_cmd_reg <= 1'b0;
            search_cmd_reg <= 1'b0;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            g_reg          <= g_next;
            op_reg         <= op_next;
            rho_reg        <= rho_next;
            cnt_reg        <= cnt_next;
            ptr_reg        <= ptr_next;
            ready_reg      <= ready_next;
            rsp_valid_reg  <= rsp_valid_next;
            found_reg      <= found_next;
            appended_reg   <= appended_next;
            node_reg       <= node_next;
            timeout_reg    <= timeout_next;
            append_cmd_reg <= append_cmd_next;
            search_cmd_reg <= search_cmd_next;
            busy_reg       <= busy_next;
            err_reg        <= err_next;
        end
    end

    // Outputs are computed one cycle early so every output comes straight
    // from a flop: the *_next values describe what the next state shows.
    always_comb begin
        state_next      = state_reg;
        g_next          = g_reg;
        op_next         = op_reg;
        rho_next        = rho_reg;
        cnt_next        = cnt_reg;
        ptr_next        = ptr_reg;
        ready_next      = '0;
        rsp_valid_next  = '0;
        found_next      = 1'b0;
        appended_next   = 1'b0;
        node_next       = '0;
        timeout_next    = 1'b0;
        append_cmd_next = 1'b0;
        search_cmd_next = 1'b0;
        err_next        = err_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    g_next          = pick_idx;
                    op_next         = req_op_i[pick_idx];
                    rho_next        = req_rho_i[pick_idx*RHO_W +: RHO_W];
                    ready_next      = pick_grant;
                    append_cmd_next = (req_op_i[pick_idx] == OP_APPEND);
                    search_cmd_next = (req_op_i[pick_idx] == OP_SEARCH);
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // done is tested first so it wins over the terminal count
                if (ll_done_i) begin
                    rsp_valid_next = ONE << g_reg;
                    found_next     = ll_found_i;
                    appended_next  = ll_append_i;
                    node_next      = ll_node_i;
                    state_next     = ST_RESP;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_next = ONE << g_reg;
                    timeout_next   = 1'b1;
                    err_next       = 1'b1;
                    state_next     = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_next   = (g_reg == IDX_W'(NREQ - 1)) ? '0 : g_reg + 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    assign req_ready_o    = ready_reg;
    assign rsp_valid_o    = rsp_valid_reg;
    assign rsp_found_o    = found_reg;
    assign rsp_appended_o = appended_reg;
    assign rsp_node_o     = node_reg;
    assign rsp_timeout_o  = timeout_reg;
    assign ll_append_o    = append_cmd_reg;
    assign ll_search_o    = search_cmd_reg;
    assign ll_rho_o       = rho_reg;
    assign busy_o         = busy_reg;
    assign err_o          = err_reg;

    // op_reg is kept with the latched request for debug visibility
    logic unused_op;
    assign unused_op = op_reg;

endmodule

// File: tb/tb_hough_ll_sched.sv
// ---------------------------------------------------------------------------
// tb_hough_ll_sched
// Bench for hough_ll_sched with a behavioural linked-list model and a
// request-level reference (per-requester FIFOs, round-robin pointer, rho map).
// ---------------------------------------------------------------------------
module tb_hough_ll_sched;
    import hough_ll_pkg::*;

    localparam int NREQ    = 4;
    localparam int RHO_W   = 10;
    localparam int NODE_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int QD      = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid_i = '0;
    logic [NREQ-1:0]       req_op_i = '0;
    logic [NREQ*RHO_W-1:0] req_rho_i = '0;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ-1:0]       rsp_valid_o;
    logic                  rsp_found_o;
    logic                  rsp_appended_o;
    logic [NODE_W-1:0]     rsp_node_o;
    logic                  rsp_timeout_o;
    logic                  ll_append_o;
    logic                  ll_search_o;
    logic [RHO_W-1:0]      ll_rho_o;
    logic                  ll_done_i = 1'b0;
    logic                  ll_append_i = 1'b0;
    logic                  ll_found_i = 1'b0;
    logic [NODE_W-1:0]     ll_node_i = '0;
    logic                  busy_o;
    logic                  err_o;

    hough_ll_sched #(
        .NREQ(NREQ), .RHO_W(RHO_W), .NODE_W(NODE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_rho_i(req_rho_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
        .rsp_found_o(rsp_found_o), .rsp_appended_o(rsp_appended_o),
        .rsp_node_o(rsp_node_o), .rsp_timeout_o(rsp_timeout_o),
        .ll_append_o(ll_append_o), .ll_search_o(ll_search_o), .ll_rho_o(ll_rho_o),
        .ll_done_i(ll_done_i), .ll_append_i(ll_append_i), .ll_found_i(ll_found_i),
        .ll_node_i(ll_node_i), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // ---------------- requester FIFOs (reference side) ----------------
    logic             pend_op  [NREQ][QD];
    logic [RHO_W-1:0] pend_rho [NREQ][QD];
    int               pend_head [NREQ];
    int               pend_cnt  [NREQ];

    task automatic push(input int k, input logic op, input logic [RHO_W-1:0] rho);
        int slot;
        slot = (pend_head[k] + pend_cnt[k]) % QD;
        pend_op[k][slot]  = op;
        pend_rho[k][slot] = rho;
        pend_cnt[k]++;
    endtask

    function automatic int pending_total();
        int s = 0;
        for (int k = 0; k < NREQ; k++) s += pend_cnt[k];
        return s;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [NODE_W-1:0] node_word(input int n, input logic [RHO_W-1:0] rho);
        return {10'h2C1, 12'(n), rho};
    endfunction

    // ---------------- expected list contents ----------------
    logic [NODE_W-1:0] exp_map [int];
    int                exp_nodes = 0;

    task automatic exp_apply(input logic op, input logic [RHO_W-1:0] rho,
                             output logic f, output logic a, output logic [NODE_W-1:0] nd);
        if (exp_map.exists(int'(rho))) begin
            f = 1'b1; a = 1'b0; nd = exp_map[int'(rho)];
        end else if (op == OP_APPEND) begin
            exp_nodes++;
            nd = node_word(exp_nodes, rho);
            exp_map[int'(rho)] = nd;
            f = 1'b0; a = 1'b1;
        end else begin
            f = 1'b0; a = 1'b0; nd = '0;
        end
    endtask

    // ---------------- behavioural linked list ----------------
    logic [NODE_W-1:0] list_map [int];
    int                list_nodes = 0;
    int                list_delay = 3;
    bit                list_nodone = 1'b0;
    bit                list_rand = 1'b0;
    int                done_at = -1;
    logic              lr_found, lr_app;
    logic [NODE_W-1:0] lr_node;

    task automatic list_apply(input logic is_app, input logic [RHO_W-1:0] rho);
        if (list_map.exists(int'(rho))) begin
            lr_found = 1'b1; lr_app = 1'b0; lr_node = list_map[int'(rho)];
        end else if (is_app) begin
            list_nodes++;
            lr_node = node_word(list_nodes, rho);
            list_map[int'(rho)] = lr_node;
            lr_found = 1'b0; lr_app = 1'b1;
        end else begin
            lr_found = 1'b0; lr_app = 1'b0; lr_node = '0;
        end
    endtask

    // ---------------- outstanding op reference ----------------
    bit                out_v = 1'b0;
    int                out_g, out_cmd_cycle, out_due;
    logic              out_op, out_tmo, out_found, out_app;
    logic [RHO_W-1:0]  out_rho;
    logic [NODE_W-1:0] out_node;
    int                model_ptr = 0;
    bit                model_err = 1'b0;
    bit                was_idle = 1'b1;
    int                cyc = 0;
    int                eg, dly;
    bit                nodone, rsp_event;
    logic [NREQ-1:0]   valid_at_edge = '0;

    always @(posedge clk) valid_at_edge <= req_valid_i;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            check_val("reset_outputs",
                {req_ready_o, rsp_valid_o, rsp_found_o, rsp_appended_o, rsp_node_o,
                 rsp_timeout_o, ll_append_o, ll_search_o, ll_rho_o, busy_o, err_o}, 64'd0);
            out_v = 1'b0; model_ptr = 0; model_err = 1'b0; was_idle = 1'b1;
            done_at = -1; ll_done_i = 1'b0; ll_found_i = 1'b0; ll_append_i = 1'b0; ll_node_i = '0;
        end else begin
            // grant: only possible if the DUT was idle during the previous cycle
            eg = was_idle ? pick(valid_at_edge, model_ptr) : -1;
            check_val("grant", req_ready_o, (eg >= 0) ? onehot(eg) : '0);
            if (eg >= 0) begin
                out_op  = pend_op[eg][pend_head[eg]];
                out_rho = pend_rho[eg][pend_head[eg]];
                check_val("cmd", {ll_append_o, ll_search_o}, out_op ? 2'b10 : 2'b01);
                check_val("ll_rho", ll_rho_o, out_rho);
                check_val("busy_issue", busy_o, 1'b1);
                exp_apply(out_op, out_rho, out_found, out_app, out_node);
                out_v = 1'b1; out_g = eg; out_cmd_cycle = cyc; out_due = cyc + TIMEOUT + 1;
                out_tmo = 1'b1;
            end else begin
                check_val("cmd_idle", {ll_append_o, ll_search_o}, 2'b00);
            end

            // list model reacts to whatever command the DUT issued
            if (ll_append_o || ll_search_o) begin
                list_apply(ll_append_o, ll_rho_o);
                if (list_rand) begin
                    nodone = ($urandom_range(0, 19) == 0);
                    dly    = $urandom_range(1, TIMEOUT);
                end else begin
                    nodone = list_nodone;
                    dly    = list_delay;
                end
                done_at = nodone ? -1 : cyc + dly;
                if (out_v && out_cmd_cycle == cyc) begin
                    out_tmo = nodone;
                    out_due = nodone ? cyc + TIMEOUT + 1 : cyc + dly + 1;
                end
            end
            if (done_at >= 0 && cyc == done_at) begin
                ll_done_i = 1'b1; ll_found_i = lr_found; ll_append_i = lr_app; ll_node_i = lr_node;
                done_at = -1;
            end else begin
                ll_done_i = 1'b0;
                ll_found_i = 1'($urandom_range(0, 1));
                ll_append_i = 1'($urandom_range(0, 1));
                ll_node_i = $urandom;
            end

            // response
            rsp_event = 1'b0;
            if (rsp_valid_o != '0 || (out_v && cyc >= out_due)) begin
                rsp_event = 1'b1;
                if (!out_v) begin
                    check_val("rsp_unexpected", rsp_valid_o, '0);
                end else begin
                    if (out_tmo) model_err = 1'b1;
                    check_val("rsp_valid", rsp_valid_o, onehot(out_g));
                    check_val("rsp_cycle", cyc - out_cmd_cycle, out_due - out_cmd_cycle);
                    check_val("rsp_timeout", rsp_timeout_o, out_tmo);
                    check_val("rsp_found", rsp_found_o, out_tmo ? 1'b0 : out_found);
                    check_val("rsp_appended", rsp_appended_o, out_tmo ? 1'b0 : out_app);
                    check_val("rsp_node", rsp_node_o, out_tmo ? '0 : out_node);
                    check_val("err", err_o, model_err);
                    check_val("busy_resp", busy_o, 1'b1);
                    $display("rsp cyc=%0d req=%0d op=%0d rho=%0d found=%0d app=%0d node=%h tmo=%0d",
                             cyc, out_g, out_op, out_rho, rsp_found_o, rsp_appended_o,
                             rsp_node_o, rsp_timeout_o);
                    model_ptr = (out_g + 1) % NREQ;
                    out_v = 1'b0;
                end
            end
            was_idle = !out_v && !rsp_event;
        end

        // requester drivers: pop on accept, present queue head (or noise when idle)
        for (int k = 0; k < NREQ; k++) begin
            if (req_ready_o[k] && pend_cnt[k] > 0) begin
                pend_head[k] = (pend_head[k] + 1) % QD;
                pend_cnt[k]--;
            end
            if (pend_cnt[k] > 0) begin
                req_valid_i[k] = 1'b1;
                req_op_i[k] = pend_op[k][pend_head[k]];
                req_rho_i[k*RHO_W +: RHO_W] = pend_rho[k][pend_head[k]];
            end else begin
                req_valid_i[k] = 1'b0;
                req_op_i[k] = 1'($urandom_range(0, 1));
                req_rho_i[k*RHO_W +: RHO_W] = RHO_W'($urandom);
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((pending_total() != 0 || out_v || !was_idle) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL idle_wait_%s: got=busy expected=idle", tag);
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        for (int k = 0; k < NREQ; k++) begin
            pend_head[k] = 0;
            pend_cnt[k] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // single append into empty list
        push(0, OP_APPEND, 10'd123);
        wait_idle("append123");

        // two requesters together right after reset
        reset_pulse();
        push(0, OP_APPEND, 10'd500);
        push(2, OP_APPEND, 10'd321);
        wait_idle("pair");

        // search miss then hit
        push(1, OP_SEARCH, 10'd789);
        wait_idle("search_miss");
        push(3, OP_SEARCH, 10'd321);
        wait_idle("search_hit");

        // all four requesters, two ops each
        for (int j = 0; j < 2; j++)
            for (int k = 0; k < NREQ; k++)
                push(k, 1'(j), RHO_W'(200 + k * 2 + j));
        wait_idle("all4");

        // timeout, then a normal op with err still set
        list_nodone = 1'b1;
        push(2, OP_APPEND, 10'd77);
        wait_idle("timeout");
        check_val("err_sticky", err_o, 1'b1);
        list_nodone = 1'b0;
        push(1, OP_SEARCH, 10'd77);
        wait_idle("after_timeout");
        check_val("err_still_set", err_o, 1'b1);

        // done on the terminal-count cycle: done wins
        list_delay = TIMEOUT;
        push(0, OP_SEARCH, 10'd123);
        wait_idle("done_at_limit");

        // reset during WAIT; requester keeps its request up and is re-granted
        list_delay = 6;
        push(1, OP_SEARCH, 10'd321);
        push(1, OP_SEARCH, 10'd321);
        n = 0;
        while (!(out_v && cyc >= out_cmd_cycle + 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        reset_pulse();
        check_val("err_cleared", err_o, 1'b0);
        wait_idle("reset_mid_wait");
        list_delay = 3;

        // randomized traffic
        list_rand = 1'b1;
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
                n = $urandom_range(0, NREQ - 1);
                if (pend_cnt[n] < 12)
                    push(n, 1'($urandom_range(0, 1)), RHO_W'($urandom_range(0, 15)));
            end
        end
        list_rand = 1'b0;
        wait_idle("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
